// File: rtl/wvb_pkg.sv
// +--------------------------------------------------------------------------+
// | wvb_pkg : shared constants for the WVB DPRAM drain                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package wvb_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_TRL   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [2:0] C_HDR_LEN        = 3'd2;
  localparam logic [2:0] C_TRL_LEN        = 3'd2;
  localparam logic [2:0] C_BYTES_PER_WORD = 3'd4;

  // The DPRAM holds at most 2**adr_w words; anything larger is trimmed.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input int adr_w);
    logic [16:0] max_len;
    max_len = 17'd1 << adr_w;
    if ({1'b0, len} > max_len) begin
      return max_len[15:0];
    end
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wvb_dpram_drain_if.sv
// +--------------------------------------------------------------------------+
// | wvb_dpram_drain_if : DPRAM read port and byte-stream link                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface wvb_dpram_drain_if #(
  parameter int P_DPRAM_ADR_WIDTH = 10
);
  logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr;
  logic                         dpram_rd_en;
  logic [31:0]                  dpram_q;
  logic [7:0]                   tx_data;
  logic                         tx_valid;
  logic                         tx_ready;

  modport master (
    output dpram_rd_addr, dpram_rd_en, tx_data, tx_valid,
    input  dpram_q, tx_ready
  );

  modport slave (
    input  dpram_rd_addr, dpram_rd_en, tx_data, tx_valid,
    output dpram_q, tx_ready
  );
endinterface

`default_nettype wire

// File: rtl/wvb_word_ser.sv
// +--------------------------------------------------------------------------+
// | wvb_word_ser : 32-bit word to MSB-first byte serializer, valid/ready hold |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wvb_word_ser (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic [31:0] word,
  input  wire logic [2:0]  nbytes,
  input  wire logic        tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             last_acc
);

  logic [31:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        w_acc;

  assign w_acc    = valid_q && tx_ready;
  assign last_acc = w_acc && (cnt_q == 3'd0);
  assign tx_data  = sh_q[31:24];
  assign tx_valid = valid_q;

  // A load may coincide with the final accept so consecutive sections need no bubble.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      sh_d    = word;
      cnt_d   = nbytes - 3'd1;
      valid_d = 1'b1;
    end else if (w_acc) begin
      if (cnt_q == 3'd0) begin
        valid_d = 1'b0;
      end else begin
        sh_d  = {sh_q[23:0], 8'h00};
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= 32'h0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wvb_dpram_drain.sv
// +--------------------------------------------------------------------------+
// | wvb_dpram_drain : drains DPRAM words to a byte link with a length header  |
// | Optional: WVB_DRAIN_CHKSUM_EN adds a 16-bit payload byte-sum trailer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wvb_dpram_drain
  import wvb_pkg::*;
#(
  parameter int P_DPRAM_ADR_WIDTH = 10
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        en,
  input  wire logic        cfg_dpram_mode,
  output logic             dpram_mode,
  input  wire logic        dpram_run,
  input  wire logic [15:0] dpram_len,
  output logic             dpram_busy,
  wvb_dpram_drain_if.master bus
);

  logic [2:0]                   state_q, state_d;
  logic [15:0]                  len_q, len_d;
  logic [P_DPRAM_ADR_WIDTH-1:0] addr_q, addr_d;
  logic                         rd_en_q, rd_en_d;
  logic                         busy_q, busy_d;
  logic                         mode_q, mode_d;
  logic                         payload_end;
  logic [16:0]                  w_word_nxt;

  logic        ser_load;
  logic [31:0] ser_word;
  logic [2:0]  ser_nbytes;
  logic        ser_last;

`ifdef WVB_DRAIN_CHKSUM_EN
  logic [15:0] chk_q, chk_d;
  logic [15:0] w_chk_nxt;

  // Includes the byte accepted this cycle so the trailer can load on the same edge.
  assign w_chk_nxt = chk_q + ((state_q == S_SEND && bus.tx_valid && bus.tx_ready)
                              ? {8'h00, bus.tx_data} : 16'h0000);
`endif

  assign w_word_nxt        = 17'(addr_q) + 17'd1;
  assign bus.dpram_rd_addr = addr_q;
  assign bus.dpram_rd_en   = rd_en_q;
  assign dpram_busy        = busy_q;
  assign dpram_mode        = mode_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    payload_end = 1'b0;
    ser_load    = 1'b0;
    ser_word    = 32'h0;
    ser_nbytes  = C_BYTES_PER_WORD;
`ifdef WVB_DRAIN_CHKSUM_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        mode_d = cfg_dpram_mode;
        if (dpram_run && en) begin
          len_d      = clamp_len(dpram_len, P_DPRAM_ADR_WIDTH);
          addr_d     = '0;
          ser_load   = 1'b1;
          ser_word   = {len_d, 16'h0000};
          ser_nbytes = C_HDR_LEN;
          state_d    = S_HDR;
`ifdef WVB_DRAIN_CHKSUM_EN
          chk_d      = 16'h0000;
`endif
        end
      end
      S_HDR: begin
        if (ser_last) begin
          if (len_q == 16'h0000) payload_end = 1'b1;
          else                   state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ser_load   = 1'b1;
        ser_word   = bus.dpram_q;
        ser_nbytes = C_BYTES_PER_WORD;
        state_d    = S_SEND;
      end
      S_SEND: begin
`ifdef WVB_DRAIN_CHKSUM_EN
        chk_d = w_chk_nxt;
`endif
        if (ser_last) begin
          addr_d = addr_q + 1'b1;
          if (w_word_nxt == {1'b0, len_q}) payload_end = 1'b1;
          else                             state_d     = S_FETCH;
        end
      end
`ifdef WVB_DRAIN_CHKSUM_EN
      S_TRL: begin
        if (ser_last) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (payload_end) begin
`ifdef WVB_DRAIN_CHKSUM_EN
      ser_load   = 1'b1;
      ser_word   = {w_chk_nxt, 16'h0000};
      ser_nbytes = C_TRL_LEN;
      state_d    = S_TRL;
`else
      state_d    = S_DONE;
`endif
    end

    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 16'h0000;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
`ifdef WVB_DRAIN_CHKSUM_EN
      chk_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
`ifdef WVB_DRAIN_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  wvb_word_ser u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .word     (ser_word),
    .nbytes   (ser_nbytes),
    .tx_ready (bus.tx_ready),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .last_acc (ser_last)
  );

endmodule

`default_nettype wire
